// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED pattern scheduler.
package led_sched_pkg;

    typedef enum logic [3:0] {
        MODE_ROTATE = 4'b0001,
        MODE_BOUNCE = 4'b0010,
        MODE_BLINK  = 4'b0100,
        MODE_MIRROR = 4'b1000
    } mode_e;

    localparam mode_e      MODE_RESET = MODE_ROTATE;
    localparam logic [7:0] PAT_RESET  = 8'h01;
    localparam logic [7:0] BLINK_ON   = 8'hFF;

    localparam int BTN_NEXT  = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_STEP  = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_ROTATE: n = MODE_BOUNCE;
            MODE_BOUNCE: n = MODE_BLINK;
            MODE_BLINK:  n = MODE_MIRROR;
            default:     n = MODE_ROTATE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_sched_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, level debouncer and rising-edge press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level_q;
    logic          level_d1;
    logic [DW-1:0] cnt_q;

    // stage p0/p1: synchroniser, then debounce on the synchronised sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            level_q  <= 1'b0;
            level_d1 <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_p0  <= raw;
            sync_p1  <= sync_p0;
            level_d1 <= level_q;
            if (sync_p1 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                level_q <= sync_p1;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + DW'(1);
            end
        end
    end

    assign press = level_q & ~level_d1;

endmodule

// File: rtl/led_sched.sv
// LED pattern scheduler: tick prescaler, mode FSM and pattern datapath.
// Optional macro LED_SCHED_PWM_EN adds PWM dimming of the pattern LEDs.
module led_sched
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int DEB_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [2:0]       press;
    logic             unused_btn;
    mode_e            mode_q, mode_d;
    logic [7:0]       pat_q, pat_d;
    logic             dir_q, dir_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             advance;
    logic [7:0]       pat_out;

    assign unused_btn = ^btn[4:3];

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk(clk), .rst(rst), .raw(btn[BTN_NEXT]), .press(press[BTN_NEXT])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
        .clk(clk), .rst(rst), .raw(btn[BTN_PAUSE]), .press(press[BTN_PAUSE])
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clk(clk), .rst(rst), .raw(btn[BTN_STEP]), .press(press[BTN_STEP])
    );

    // Returns {dir, pat} after one pattern step in the given mode.
    function automatic logic [8:0] advance_pat(input mode_e m, input logic [7:0] p,
                                               input logic d);
        logic [7:0] np;
        logic       nd;
        np = p;
        nd = d;
        case (m)
            MODE_ROTATE: np = {p[6:0], p[7]};
            MODE_BOUNCE: begin
                if (d == DIR_LEFT) begin
                    np = p << 1;
                    if (np[7]) nd = DIR_RIGHT;
                end else begin
                    np = p >> 1;
                    if (np[0]) nd = DIR_LEFT;
                end
            end
            MODE_BLINK:  np = (p == BLINK_ON) ? 8'h00 : BLINK_ON;
            default:     np = p;
        endcase
        return {nd, np};
    endfunction

    // A paused counter sits still, so the tick must be gated or it would repeat.
    assign tick    = !paused_q && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign advance = tick || (press[BTN_STEP] && paused_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q   <= MODE_RESET;
            pat_q    <= PAT_RESET;
            dir_q    <= DIR_LEFT;
            paused_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        pat_d    = pat_q;
        dir_d    = dir_q;
        paused_d = paused_q;
        cnt_d    = cnt_q;

        if (press[BTN_PAUSE]) paused_d = !paused_q;

        // A mode change wins over both tick and step in the same cycle.
        if (press[BTN_NEXT]) begin
            mode_d = next_mode(mode_q);
            cnt_d  = '0;
            dir_d  = DIR_LEFT;
            case (mode_d)
                MODE_BLINK:  pat_d = BLINK_ON;
                MODE_MIRROR: pat_d = sw;
                default:     pat_d = PAT_RESET;
            endcase
        end else begin
            if (!paused_q) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (mode_q == MODE_MIRROR) begin
                pat_d = sw;
            end else if (advance) begin
                {dir_d, pat_d} = advance_pat(mode_q, pat_q, dir_q);
            end
        end
    end

`ifdef LED_SCHED_PWM_EN
    logic [3:0] pwm_q;
    logic       pwm_on;

    always_ff @(posedge clk) begin
        if (!rst) pwm_q <= '0;
        else      pwm_q <= pwm_q + 4'd1;
    end

    // 5-bit compare so that sw[3:0]=F gives a permanently-on duty.
    assign pwm_on  = {1'b0, pwm_q} < ({1'b0, sw[3:0]} + 5'd1);
    assign pat_out = pat_q & {8{pwm_on}};
`else
    assign pat_out = pat_q;
`endif

    assign ledr = {pat_out, mode_q, paused_q, 3'b000};

endmodule

// File: tb/tb_led_sched.sv
// Self-checking bench for led_sched: directed vector table plus randomized run vs reference model.
module tb_led_sched;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btn = '0;
    logic [7:0]  sw  = '0;
    logic [15:0] ledr;

    int checks = 0;
    int errors = 0;

    led_sched #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw), .ledr(ledr)
    );

    always #5 clk = ~clk;

    // Reference model: pattern as integers, mode as an index 0..3 (ROTATE..MIRROR),
    // bounce as a position/direction pair, debouncer as a sample history window.
    int          m_cnt, m_mode, m_pat, m_pos, m_dir, m_paused, m_pwm;
    bit          m_lvl [3];
    bit          m_lvlp[3];
    bit          m_s0  [3];
    bit          m_s1  [3];
    logic [63:0] m_hist[3];
    int          m_n   [3];

    task automatic model_edge(input logic r, input logic [4:0] b, input logic [7:0] s);
        bit          pr[3];
        bit          tk, adv, was_paused;
        logic [63:0] mask;
        mask = (64'd1 << DEB_CYCLES) - 64'd1;
        if (!r) begin
            m_cnt = 0; m_mode = 0; m_pat = 1; m_pos = 0; m_dir = 1; m_paused = 0; m_pwm = 0;
            for (int i = 0; i < 3; i++) begin
                m_lvl[i] = 0; m_lvlp[i] = 0; m_s0[i] = 0; m_s1[i] = 0; m_hist[i] = '0; m_n[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) pr[i] = m_lvl[i] && !m_lvlp[i];
            was_paused = (m_paused != 0);
            tk  = !was_paused && (m_cnt == TICK_DIV - 1);
            adv = tk || (pr[2] && was_paused);
            if (pr[1]) m_paused = was_paused ? 0 : 1;
            if (pr[0]) begin
                m_mode = (m_mode + 1) % 4;
                m_cnt = 0; m_pos = 0; m_dir = 1;
                m_pat = (m_mode == 2) ? 255 : (m_mode == 3) ? int'(s) : 1;
            end else begin
                if (!was_paused) m_cnt = (m_cnt + 1) % TICK_DIV;
                if (m_mode == 3) m_pat = int'(s);
                else if (adv) begin
                    case (m_mode)
                        0: m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
                        1: begin
                            m_pos = m_pos + m_dir;
                            if (m_pos == 7) m_dir = -1;
                            else if (m_pos == 0) m_dir = 1;
                            m_pat = 1 << m_pos;
                        end
                        default: m_pat = 255 - m_pat;
                    endcase
                end
            end
            m_pwm = (m_pwm + 1) % 16;
            for (int i = 0; i < 3; i++) begin
                m_lvlp[i] = m_lvl[i];
                m_hist[i] = {m_hist[i][62:0], m_s1[i]};
                if (m_n[i] < 64) m_n[i]++;
                if (m_n[i] >= DEB_CYCLES &&
                    ((m_hist[i] & mask) == (m_lvl[i] ? 64'd0 : mask))) begin
                    m_lvl[i] = !m_lvl[i];
                    m_n[i] = 0;
                end
                m_s1[i] = m_s0[i];
                m_s0[i] = b[i];
            end
        end
    endtask

    function automatic logic [15:0] model_ledr();
        logic [7:0] p;
        logic [3:0] oh;
        p  = 8'(m_pat);
        oh = 4'(1 << m_mode);
`ifdef LED_SCHED_PWM_EN
        if (!(m_pwm < int'(sw[3:0]) + 1)) p = 8'h00;
`endif
        return {p, oh, (m_paused != 0), 3'b000};
    endfunction

    always @(posedge clk) model_edge(rst, btn, sw);

    task automatic check(input string nm, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: ledr=%h expected %h", nm, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic [4:0]  b;
        logic [7:0]  s;
        int          cyc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[28];

    initial begin
        logic [15:0] vmask;
        int          hold;
`ifdef LED_SCHED_PWM_EN
        vmask = 16'h00FF;
`else
        vmask = 16'hFFFF;
`endif
        // r, btn, sw, cycles to run, ledr after those cycles (TICK_DIV=4, DEB_CYCLES=3)
        vecs[0]  = '{1'b0, 5'd0, 8'h00,  2, 16'h0110};  // reset
        vecs[1]  = '{1'b1, 5'd0, 8'h00,  3, 16'h0110};  // cnt 1..3
        vecs[2]  = '{1'b1, 5'd0, 8'h00,  1, 16'h0210};  // first tick
        vecs[3]  = '{1'b1, 5'd0, 8'h00,  4, 16'h0410};
        vecs[4]  = '{1'b1, 5'd1, 8'h00,  5, 16'h0810};  // next held: not yet
        vecs[5]  = '{1'b1, 5'd1, 8'h00,  1, 16'h0120};  // raw+6: BOUNCE
        vecs[6]  = '{1'b1, 5'd0, 8'h00,  4, 16'h0220};
        vecs[7]  = '{1'b1, 5'd0, 8'h00,  4, 16'h0420};
        vecs[8]  = '{1'b1, 5'd1, 8'h00,  2, 16'h0420};  // 2-cycle glitch
        vecs[9]  = '{1'b1, 5'd0, 8'h00,  6, 16'h1020};  // glitch ignored
        vecs[10] = '{1'b1, 5'd2, 8'h00,  6, 16'h2028};  // pause
        vecs[11] = '{1'b1, 5'd0, 8'h00, 10, 16'h2028};  // frozen
        vecs[12] = '{1'b1, 5'd4, 8'h00,  6, 16'h4028};  // step while paused
        vecs[13] = '{1'b1, 5'd0, 8'h00,  8, 16'h4028};
        vecs[14] = '{1'b1, 5'd5, 8'h00,  6, 16'hFF48};  // next+step: BLINK, no advance
        vecs[15] = '{1'b1, 5'd0, 8'h00,  8, 16'hFF48};
        vecs[16] = '{1'b1, 5'd4, 8'h00,  6, 16'h0048};  // step toggles blink
        vecs[17] = '{1'b1, 5'd0, 8'h00,  8, 16'h0048};
        vecs[18] = '{1'b1, 5'd2, 8'h00,  6, 16'h0040};  // unpause
        vecs[19] = '{1'b1, 5'd0, 8'h00,  4, 16'hFF40};
        vecs[20] = '{1'b1, 5'd4, 8'h00,  6, 16'h0040};  // step while running ignored
        vecs[21] = '{1'b1, 5'd0, 8'h00,  1, 16'h0040};
        vecs[22] = '{1'b1, 5'd1, 8'hA5,  6, 16'hA580};  // MIRROR
        vecs[23] = '{1'b1, 5'd0, 8'h3C,  8, 16'h3C80};
        vecs[24] = '{1'b1, 5'd1, 8'h3C,  6, 16'h0110};  // back to ROTATE
        vecs[25] = '{1'b1, 5'd0, 8'h00,  4, 16'h0210};
        vecs[26] = '{1'b0, 5'd0, 8'h00,  1, 16'h0110};  // reset mid-run
        vecs[27] = '{1'b1, 5'd0, 8'h00,  1, 16'h0110};

        for (int i = 0; i < 28; i++) begin
            rst = vecs[i].r;
            btn = vecs[i].b;
            sw  = vecs[i].s;
            for (int c = 0; c < vecs[i].cyc; c++) begin
                @(posedge clk);
                #1;
            end
            check("vec", i, ledr & vmask, vecs[i].exp & vmask);
        end

        // Bounce end bits each shown for exactly one tick.
        rst = 1'b1; btn = 5'd1; sw = 8'h00;
        repeat (6) begin @(posedge clk); #1; end
        btn = 5'd0;
        for (int t = 0; t < 16; t++) begin
            repeat (TICK_DIV) begin @(posedge clk); #1; end
            check("bounce", t, ledr & vmask, model_ledr() & vmask);
        end

        // Randomized run against the reference model.
        for (int seg = 0; seg < 450; seg++) begin
            rst  = ($urandom_range(0, 59) != 0);
            btn  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            sw   = 8'($urandom);
            hold = $urandom_range(1, 10);
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                check("rand", seg, ledr, model_ledr());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
